// File: rtl/l2_cache_pkg.sv
// Shared types for the L2 cache: LC-3b word/line types and FSM states.
// Imported by l2_array and l2_cache.
package l2_cache_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cacheline;
    typedef logic [3:0]   lc3b_l2_offset;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE,
        S_RESPOND
    } l2_state_e;

endpackage

// File: rtl/l2_cache_array.sv
// l2_array: 2^S_IDX x WIDTH storage, sync write on load, async read.
// Ports: clk, reset, load, index, din -> dout. CLEAR=1 zeroes on reset.
module l2_array
    import l2_cache_pkg::*;
#(
    parameter int S_IDX = 3,
    parameter int WIDTH = 1,
    parameter bit CLEAR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [S_IDX-1:0] index,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int N = 1 << S_IDX;

    logic [WIDTH-1:0] mem_q [N];
    logic [WIDTH-1:0] mem_d [N];

    always_comb begin
        mem_d = mem_q;
        if (load) begin
            mem_d[index] = din;
        end
    end

    generate
        if (CLEAR) begin : g_clr
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_q <= '{default: '0};
                end else begin
                    mem_q <= mem_d;
                end
            end
        end else begin : g_keep
            always_ff @(posedge clk) begin
                mem_q <= mem_d;
            end
        end
    endgenerate

    assign dout = mem_q[index];

endmodule

// File: rtl/l2_cache.sv
// l2_cache: direct-mapped write-back L2 between L1 (l2_*) and pmem (pmem_*).
// Ports: clk, reset, l2 read/write/addr/wdata -> resp/rdata; pmem req/resp.
module l2_cache
    import l2_cache_pkg::*;
#(
    parameter int S_IDX = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          l2_read,
    input  logic          l2_write,
    input  lc3b_word      l2_address,
    input  lc3b_cacheline l2_wdata,
    output logic          l2_resp,
    output lc3b_cacheline l2_rdata,
    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_word      pmem_address,
    output lc3b_cacheline pmem_wdata,
    input  lc3b_cacheline pmem_rdata,
    input  logic          pmem_resp
);

    localparam int TAG_W = 12 - S_IDX;

    logic [S_IDX-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             unused_ok;

    assign idx       = l2_address[3+S_IDX:4];
    assign tag       = l2_address[15:4+S_IDX];
    assign unused_ok = ^l2_address[3:0];

    l2_state_e     state_q, state_d;
    logic          resp_q, resp_d;
    lc3b_cacheline rdata_q, rdata_d;
    logic          pmem_read_q, pmem_read_d;
    logic          pmem_write_q, pmem_write_d;

    logic          data_ld, tag_ld, valid_ld, dirty_ld;
    logic          dirty_in;
    lc3b_cacheline data_in, data_out;
    logic [TAG_W-1:0] tag_out;
    logic          valid_out, dirty_out;

    logic rd_req, wr_req, hit;

    assign rd_req = l2_read & ~l2_write;
    assign wr_req = l2_write & ~l2_read;
    assign hit    = valid_out & (tag_out == tag);

    l2_array #(.S_IDX(S_IDX), .WIDTH(128), .CLEAR(1'b0)) u_data (
        .clk   (clk),
        .reset (reset),
        .load  (data_ld),
        .index (idx),
        .din   (data_in),
        .dout  (data_out)
    );

    l2_array #(.S_IDX(S_IDX), .WIDTH(TAG_W), .CLEAR(1'b0)) u_tag (
        .clk   (clk),
        .reset (reset),
        .load  (tag_ld),
        .index (idx),
        .din   (tag),
        .dout  (tag_out)
    );

    l2_array #(.S_IDX(S_IDX), .WIDTH(1), .CLEAR(1'b1)) u_valid (
        .clk   (clk),
        .reset (reset),
        .load  (valid_ld),
        .index (idx),
        .din   (1'b1),
        .dout  (valid_out)
    );

    l2_array #(.S_IDX(S_IDX), .WIDTH(1), .CLEAR(1'b1)) u_dirty (
        .clk   (clk),
        .reset (reset),
        .load  (dirty_ld),
        .index (idx),
        .din   (dirty_in),
        .dout  (dirty_out)
    );

    always_comb begin
        state_d      = state_q;
        resp_d       = 1'b0;
        rdata_d      = rdata_q;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
        data_ld      = 1'b0;
        tag_ld       = 1'b0;
        valid_ld     = 1'b0;
        dirty_ld     = 1'b0;
        dirty_in     = 1'b0;
        data_in      = l2_wdata;

        unique case (state_q)
            S_IDLE: begin
                if (rd_req | wr_req) begin
                    if (hit) begin
                        if (wr_req) begin
                            data_ld  = 1'b1;
                            dirty_ld = 1'b1;
                            dirty_in = 1'b1;
                            rdata_d  = l2_wdata;
                        end else begin
                            rdata_d  = data_out;
                        end
                        resp_d  = 1'b1;
                        state_d = S_RESPOND;
                    end else if (valid_out & dirty_out) begin
                        pmem_write_d = 1'b1;
                        state_d      = S_WRITEBACK;
                    end else if (rd_req) begin
                        pmem_read_d = 1'b1;
                        state_d     = S_ALLOCATE;
                    end else begin
                        // Full-line write: no fetch needed.
                        data_ld  = 1'b1;
                        tag_ld   = 1'b1;
                        valid_ld = 1'b1;
                        dirty_ld = 1'b1;
                        dirty_in = 1'b1;
                        rdata_d  = l2_wdata;
                        resp_d   = 1'b1;
                        state_d  = S_RESPOND;
                    end
                end
            end
            S_WRITEBACK: begin
                pmem_write_d = 1'b1;
                if (pmem_resp) begin
                    pmem_write_d = 1'b0;
                    dirty_ld     = 1'b1;
                    dirty_in     = 1'b0;
                    if (wr_req) begin
                        // Victim is out; install the new line dirty.
                        data_ld  = 1'b1;
                        tag_ld   = 1'b1;
                        valid_ld = 1'b1;
                        dirty_in = 1'b1;
                        rdata_d  = l2_wdata;
                        resp_d   = 1'b1;
                        state_d  = S_RESPOND;
                    end else begin
                        pmem_read_d = 1'b1;
                        state_d     = S_ALLOCATE;
                    end
                end
            end
            S_ALLOCATE: begin
                pmem_read_d = 1'b1;
                if (pmem_resp) begin
                    pmem_read_d = 1'b0;
                    data_in     = pmem_rdata;
                    data_ld     = 1'b1;
                    tag_ld      = 1'b1;
                    valid_ld    = 1'b1;
                    dirty_ld    = 1'b1;
                    dirty_in    = 1'b0;
                    rdata_d     = pmem_rdata;
                    resp_d      = 1'b1;
                    state_d     = S_RESPOND;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            resp_q       <= 1'b0;
            rdata_q      <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_q       <= resp_d;
            rdata_q      <= rdata_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
        end
    end

    assign l2_resp    = resp_q;
    assign l2_rdata   = rdata_q;
    assign pmem_read  = pmem_read_q;
    assign pmem_write = pmem_write_q;
    assign pmem_wdata = data_out;

    // Victim address during writeback, requested line otherwise.
    assign pmem_address = (state_q == S_WRITEBACK)
                        ? {tag_out, idx, 4'h0}
                        : {l2_address[15:4], 4'h0};

endmodule

// File: tb/tb_l2_cache.sv
// Testbench for l2_cache: random + directed traffic vs a flat-memory model.
// Scoreboard queue of expected responses checked by an l2_resp monitor.
module tb_l2_cache;

    logic         clk = 1'b0;
    logic         reset;
    logic         l2_read, l2_write;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata;
    logic         l2_resp;
    logic [127:0] l2_rdata;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    l2_cache #(.S_IDX(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .l2_read      (l2_read),
        .l2_write     (l2_write),
        .l2_address   (l2_address),
        .l2_wdata     (l2_wdata),
        .l2_resp      (l2_resp),
        .l2_rdata     (l2_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    typedef struct {
        logic [127:0] rdata;
        bit           wb;
        logic [15:0]  wb_addr;
        logic [127:0] wb_data;
        bit           fill;
        logic [15:0]  fill_addr;
        int           lat;
    } exp_t;

    typedef struct {
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] data;
    } ev_t;

    exp_t exp_q[$];
    ev_t  ev_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    bit stall = 1'b0;

    // Backing memory and the line values the L1 should observe.
    logic [127:0] mem    [logic [15:0]];
    logic [127:0] shadow [logic [15:0]];

    // Which line each set currently holds (no data: data lives in shadow).
    bit          m_v [8];
    bit          m_d [8];
    logic [8:0]  m_t [8];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] init_line(logic [15:0] a);
        logic [15:0] m3;
        m3 = 16'(a * 16'd3);
        return {a, a ^ 16'hA5A5, ~a, a + 16'h1111,
                {a[7:0], a[15:8]}, a ^ 16'h3C3C, m3, a ^ 16'hBEEF};
    endfunction

    function automatic logic [127:0] mem_val(logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return init_line(a);
    endfunction

    function automatic logic [127:0] exp_read(logic [15:0] a);
        if (shadow.exists(a)) return shadow[a];
        return mem_val(a);
    endfunction

    function automatic void chk(string nm, logic [127:0] act,
                                logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = 1'b0;
        end
        shadow.delete();
        ev_q.delete();
    endfunction

    // pmem responder: random latency, records every transfer it sees.
    initial begin
        bit          busy;
        int          wn;
        logic [15:0] ca;
        ev_t         ev;
        busy = 1'b0;
        wn = 0;
        ca = '0;
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (!(pmem_read || pmem_write)) begin
                busy = 1'b0;
            end else begin
                chk("pmem_excl", 128'(pmem_read & pmem_write), 128'(0));
                if (!busy) begin
                    busy = 1'b1;
                    wn = $urandom_range(1, 3);
                    ca = pmem_address;
                    chk("pmem_align", 128'(pmem_address[3:0]), 128'(0));
                    ev.wr = pmem_write;
                    ev.addr = pmem_address;
                    ev.data = pmem_wdata;
                    ev_q.push_back(ev);
                end else begin
                    chk("pmem_addr_stable", 128'(pmem_address), 128'(ca));
                end
                if (wn == 0 && !stall) begin
                    if (pmem_write) mem[pmem_address] = pmem_wdata;
                    else pmem_rdata = mem_val(pmem_address);
                    pmem_resp = 1'b1;
                    busy = 1'b0;
                end else if (wn > 0) begin
                    wn--;
                end
            end
        end
    end

    // Monitor: every l2_resp pops one expectation.
    initial begin
        exp_t e;
        int   nexp;
        int   k;
        forever begin
            @(negedge clk);
            if (l2_resp === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got 1 want 0");
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", l2_rdata, e.rdata);
                    nexp = int'(e.wb) + int'(e.fill);
                    chk("pmem_count", 128'(ev_q.size()), 128'(nexp));
                    if (ev_q.size() == nexp) begin
                        k = 0;
                        if (e.wb) begin
                            chk("wb_is_write", 128'(ev_q[0].wr), 128'(1));
                            chk("wb_addr", 128'(ev_q[0].addr),
                                128'(e.wb_addr));
                            chk("wb_data", ev_q[0].data, e.wb_data);
                            k = 1;
                        end
                        if (e.fill) begin
                            chk("fill_is_read", 128'(ev_q[k].wr), 128'(0));
                            chk("fill_addr", 128'(ev_q[k].addr),
                                128'(e.fill_addr));
                        end
                    end
                    if (e.lat >= 0)
                        chk("latency", 128'(cyc - start_cyc), 128'(e.lat));
                    ev_q.delete();
                end
            end
        end
    end

    task automatic idle(int n);
        l2_read = 1'b0;
        l2_write = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issues one request and returns in the IDLE cycle after RESPOND,
    // still driving it; the caller must change the request immediately.
    task automatic txn(bit wr, logic [15:0] a, logic [127:0] d);
        exp_t        e;
        logic [15:0] la;
        int          s;
        logic [8:0]  tg;
        int          n;
        la = {a[15:4], 4'h0};
        s = int'(a[6:4]);
        tg = a[15:7];
        n = 0;
        e.rdata = '0;
        e.wb = 1'b0;
        e.wb_addr = '0;
        e.wb_data = '0;
        e.fill = 1'b0;
        e.fill_addr = '0;
        e.lat = -1;
        if (m_v[s] && m_t[s] == tg) begin
            e.lat = 1;
            if (wr) begin
                shadow[la] = d;
                m_d[s] = 1'b1;
                e.rdata = d;
            end else begin
                e.rdata = exp_read(la);
            end
        end else begin
            if (m_v[s] && m_d[s]) begin
                e.wb = 1'b1;
                e.wb_addr = {m_t[s], 3'(s), 4'h0};
                e.wb_data = exp_read(e.wb_addr);
            end
            if (wr) begin
                shadow[la] = d;
                e.rdata = d;
                m_d[s] = 1'b1;
                if (!e.wb) e.lat = 1;
            end else begin
                e.fill = 1'b1;
                e.fill_addr = la;
                e.rdata = exp_read(la);
                m_d[s] = 1'b0;
            end
            m_v[s] = 1'b1;
            m_t[s] = tg;
        end
        exp_q.push_back(e);
        ev_q.delete();
        l2_read = !wr;
        l2_write = wr;
        l2_address = a;
        l2_wdata = d;
        start_cyc = cyc;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (l2_resp !== 1'b1 && n < 100);
        if (l2_resp !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got 0 want 1 addr %h", a);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
            l2_read = 1'b0;
            l2_write = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] lb;
        logic [15:0]  ra;
        int           n;
        reset = 1'b1;
        l2_read = 1'b0;
        l2_write = 1'b0;
        l2_address = '0;
        l2_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp", 128'(l2_resp), 128'(0));
        chk("rst_pmem_read", 128'(pmem_read), 128'(0));
        chk("rst_pmem_write", 128'(pmem_write), 128'(0));
        chk("rst_rdata", l2_rdata, 128'(0));
        reset = 1'b0;
        idle(1);

        // Fill, then hit.
        txn(1'b0, 16'h1230, '0);
        txn(1'b0, 16'h1230, '0);
        // Write hit, read back.
        lb = rnd_line();
        txn(1'b1, 16'h1230, lb);
        txn(1'b0, 16'h1230, '0);
        idle(2);
        // Dirty conflict: writeback then fill.
        txn(1'b0, 16'h5230, '0);
        idle(1);
        // Write miss on an invalid set, then evict it dirty.
        txn(1'b1, 16'h0040, rnd_line());
        txn(1'b0, 16'h0040, '0);
        txn(1'b0, 16'h1040, '0);
        // Write then read with no gap.
        txn(1'b1, 16'h2230, rnd_line());
        txn(1'b0, 16'h2238, '0);

        // Both strobes high: no request.
        l2_read = 1'b1;
        l2_write = 1'b1;
        l2_address = 16'h3300;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("both_high_resp", 128'(l2_resp), 128'(0));
            chk("both_high_pmem", 128'(pmem_read | pmem_write), 128'(0));
        end
        idle(2);

        // Reset in the middle of a fill.
        stall = 1'b1;
        l2_read = 1'b1;
        l2_write = 1'b0;
        l2_address = 16'h7770;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (pmem_read !== 1'b1 && n < 20);
        chk("alloc_started", 128'(pmem_read), 128'(1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        l2_read = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_alloc_drop", 128'(pmem_read), 128'(0));
        chk("rst_alloc_resp", 128'(l2_resp), 128'(0));
        reset = 1'b0;
        stall = 1'b0;
        model_reset();
        idle(1);
        txn(1'b0, 16'h7770, '0);
        idle(1);

        // Random traffic over a small tag pool to force conflicts.
        for (int i = 0; i < 200; i++) begin
            ra = {7'd0, 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            txn(1'($urandom_range(0, 1)), ra, rnd_line());
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(4);

        chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l2_cache.md
# l2_cache

Direct-mapped, write-back L2 cache that acts as the responder for the L1 cache's `l2_*` request interface and as the initiator toward physical memory on the `pmem_*` interface. It services whole-cacheline reads (L1 line fills) and whole-cacheline writes (L1 dirty evictions). It holds dirty lines locally until they are evicted.

## Interface
- `S_IDX`, default 3: index width; the cache has 2^S_IDX sets. Tag width = 16 − 4 − S_IDX.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `l2_read`  in  1  L1 line-fill request; held until `l2_resp`.
- `l2_write`  in  1  L1 line-writeback request; held until `l2_resp`.
- `l2_address`  in  16 (`lc3b_word`)  byte address; bits [3:0] ignored.
- `l2_wdata`  in  128 (`lc3b_cacheline`)  line to write; stable while `l2_write`.
- `l2_resp`  out  1  one-cycle completion pulse.
- `l2_rdata`  out  128  returned line; valid only while `l2_resp`=1.
- `pmem_read`, `pmem_write`  out  1 each  memory request; held until `pmem_resp`.
- `pmem_address`  out  16  line-aligned address ([3:0]=0).
- `pmem_wdata`  out  128  victim line.
- `pmem_rdata`  in  128  fill data; valid when `pmem_resp`=1.
- `pmem_resp`  in  1  memory completion pulse.

## Operation
- Address split: offset [3:0], index [3+S_IDX:4], tag [15:4+S_IDX].
- Per set: valid bit, dirty bit, tag, 128-bit data.
- Request decode: read = `l2_read & ~l2_write`; write = `l2_write & ~l2_read`. Both high or both low means no request. Such a cycle is ignored and produces no `l2_resp`.
- States: IDLE, WRITEBACK, ALLOCATE, RESPOND.
- IDLE with a request:
  - Hit (valid and tag match):
    - Write hit: store `l2_wdata` and set dirty.
    - Read hit: latch the line into `l2_rdata`.
    - Next state: RESPOND.
  - Miss, victim valid and dirty: go to WRITEBACK.
  - Read miss, victim clean or invalid: go to ALLOCATE.
  - Write miss, victim clean or invalid: install the line directly with tag, valid=1, dirty=1. No memory fetch (full-line write). Next state: RESPOND.
- WRITEBACK:
  - Outputs: `pmem_write`=1, `pmem_address`={victim tag, index, 4'b0}, `pmem_wdata`=victim data.
  - On `pmem_resp`: clear dirty.
    - Read request: go to ALLOCATE.
    - Write request: install the line as in a write miss, then go to RESPOND.
- ALLOCATE:
  - Outputs: `pmem_read`=1, `pmem_address`={`l2_address`[15:4], 4'b0}.
  - On `pmem_resp`: write `pmem_rdata` with tag, valid=1, dirty=0. Latch `pmem_rdata` into `l2_rdata`. Next state: RESPOND.
- RESPOND: `l2_resp`=1, then go to IDLE unconditionally.
  - The request is still asserted during this cycle and is never re-sampled in it.
- After a write, `l2_rdata` returns the line just written.
- `pmem_resp` outside WRITEBACK or ALLOCATE is ignored.
- Reset:
  - State goes to IDLE; all valid and dirty bits clear.
  - `l2_resp`, `pmem_read`, `pmem_write` = 0; `l2_rdata` = 0.
  - Data and tag arrays are not reset.
  - Reset during WRITEBACK or ALLOCATE abandons the transfer: no `l2_resp`, and the pmem request drops on the next cycle.

## Timing
- Hit: request seen in IDLE at cycle t → `l2_resp` at t+1. A new request is accepted in IDLE at t+2.
- Miss, clean victim: `l2_resp` one cycle after the fill `pmem_resp`.
- Miss, dirty victim: WRITEBACK → ALLOCATE → RESPOND; one pmem transaction after the other, never overlapping.
- `pmem_read` and `pmem_write` are never high together. Their address and data are stable for the whole request.
- The L1 may switch from write to read (evict then fill) in the cycle right after `l2_resp`. The next IDLE cycle must accept it with no bubble beyond that IDLE cycle.
- Array writes happen on the `clk` edge that leaves the current state. Array reads are combinational.

## Structure
- `lc3b_types` gains `lc3b_l2_offset` (4 bits). It already supplies `lc3b_word` and `lc3b_cacheline`.
- Sub-module `l2_array #(S_IDX, WIDTH)`: 2^S_IDX entries, synchronous write with `load`, asynchronous read, contents cleared on `reset` (cleared only where used for valid and dirty).
- It is instantiated four times: data, tag, valid, dirty.
- Control is an FSM inside `l2_cache`.

## Test plan
- Reset, then read 0x1230 with `pmem_rdata`=A after 3 cycles:
  - One `pmem_read` at 0x1230.
  - `l2_resp` with `l2_rdata`=A.
  - A repeat read hits with `l2_resp` at t+1 and no pmem activity.
- Write line B to 0x1230 (hit), then read 0x1230:
  - Returns B.
  - No pmem traffic.
- With 0x1230 dirty, read 0x5230 (same index 3, different tag):
  - `pmem_write` at 0x1230 with data B, then `pmem_read` at 0x5230, then `l2_resp`.
- Write miss to 0x0040 on an invalid set:
  - `l2_resp` at t+1 with no pmem activity.
  - Set 4 becomes dirty.
- Back-to-back traffic: `l2_write` held until resp, then `l2_read` in the next cycle:
  - Exactly two `l2_resp` pulses.
  - `l2_read` and `l2_write` both high is ignored.
- Assert `reset` mid-ALLOCATE:
  - No `l2_resp`; pmem request drops.
  - The next read of the same address misses.
